// File: rtl/aes_serdes_driver.sv
// Block-to-beat adapter for a beat-serial AES core: serialises key/plaintext MSB-first,
// collects ciphertext beats into a block and guards the wait for results with a watchdog.
module aes_serdes_driver #(
    parameter int unsigned BLK_W   = 128,
    parameter int unsigned BUS_W   = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [BLK_W-1:0] i_s_key,
    input  logic [BLK_W-1:0] i_s_data,
    output logic             o_core_rst,
    output logic [BUS_W-1:0] o_core_key,
    output logic [BUS_W-1:0] o_core_din,
    input  logic [BUS_W-1:0] i_core_dout,
    input  logic             i_core_dvld,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [BLK_W-1:0] o_m_data,
    output logic             o_m_timeout
);

    localparam int unsigned BEATS = BLK_W / BUS_W;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ALL_OUT = CNT_W'(BEATS);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

    state_e             r_state, w_state_nxt;
    logic               r_s_ready, w_s_ready_nxt;
    logic               r_core_rst, w_core_rst_nxt;
    logic [BUS_W-1:0]   r_core_key, w_core_key_nxt;
    logic [BUS_W-1:0]   r_core_din, w_core_din_nxt;
    logic [BLK_W-1:0]   r_key_sh, w_key_sh_nxt;
    logic [BLK_W-1:0]   r_din_sh, w_din_sh_nxt;
    logic               r_m_valid, w_m_valid_nxt;
    logic [BLK_W-1:0]   r_m_data, w_m_data_nxt;
    logic               r_m_timeout, w_m_timeout_nxt;
    logic [CNT_W-1:0]   r_in_cnt, w_in_cnt_nxt;
    logic [CNT_W-1:0]   r_out_cnt, w_out_cnt_nxt;
    logic [TMO_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;

    logic w_accept, w_beat_in, w_last_out, w_tmo;

    assign w_accept   = (r_state == StIdle) && i_s_valid && r_s_ready;
    assign w_beat_in  = ((r_state == StLoad) || (r_state == StWait)) && i_core_dvld;
    assign w_last_out = w_beat_in && ((r_out_cnt + 1'b1) == ALL_OUT);
    // A final beat on the watchdog's last cycle completes the block normally.
    assign w_tmo      = (r_state == StWait) && ((r_wait_cnt + 1'b1) == TMO_LIM) && !w_last_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_nxt = StLoad;
            StLoad: begin
                if (w_last_out)               w_state_nxt = StDone;
                else if (r_in_cnt == LAST_IN) w_state_nxt = StWait;
            end
            StWait: if (w_last_out || w_tmo) w_state_nxt = StDone;
            StDone: if (i_m_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_s_ready_nxt   = (w_state_nxt == StIdle);
        w_core_rst_nxt  = !((w_state_nxt == StLoad) || (w_state_nxt == StWait));
        w_m_valid_nxt   = (w_state_nxt == StDone);
        w_core_key_nxt  = '0;
        w_core_din_nxt  = '0;
        w_key_sh_nxt    = r_key_sh;
        w_din_sh_nxt    = r_din_sh;
        w_in_cnt_nxt    = r_in_cnt;
        w_out_cnt_nxt   = r_out_cnt;
        w_m_data_nxt    = r_m_data;
        w_m_timeout_nxt = r_m_timeout;
        w_wait_cnt_nxt  = (r_state == StWait) ? r_wait_cnt + 1'b1 : '0;

        if (w_accept) begin
            w_core_key_nxt  = i_s_key[BLK_W-1 -: BUS_W];
            w_core_din_nxt  = i_s_data[BLK_W-1 -: BUS_W];
            w_key_sh_nxt    = i_s_key << BUS_W;
            w_din_sh_nxt    = i_s_data << BUS_W;
            w_in_cnt_nxt    = '0;
            w_out_cnt_nxt   = '0;
            w_m_data_nxt    = '0;
            w_m_timeout_nxt = 1'b0;
        end else if ((r_state == StLoad) && (w_state_nxt == StLoad)) begin
            w_core_key_nxt = r_key_sh[BLK_W-1 -: BUS_W];
            w_core_din_nxt = r_din_sh[BLK_W-1 -: BUS_W];
            w_key_sh_nxt   = r_key_sh << BUS_W;
            w_din_sh_nxt   = r_din_sh << BUS_W;
            w_in_cnt_nxt   = r_in_cnt + 1'b1;
        end

        if (w_beat_in) begin
            w_m_data_nxt  = {r_m_data[BLK_W-BUS_W-1:0], i_core_dout};
            w_out_cnt_nxt = r_out_cnt + 1'b1;
        end
        if (w_tmo) w_m_timeout_nxt = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_ready   <= 1'b0;
            r_core_rst  <= 1'b1;
            r_core_key  <= '0;
            r_core_din  <= '0;
            r_key_sh    <= '0;
            r_din_sh    <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_timeout <= 1'b0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_s_ready   <= w_s_ready_nxt;
            r_core_rst  <= w_core_rst_nxt;
            r_core_key  <= w_core_key_nxt;
            r_core_din  <= w_core_din_nxt;
            r_key_sh    <= w_key_sh_nxt;
            r_din_sh    <= w_din_sh_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_data    <= w_m_data_nxt;
            r_m_timeout <= w_m_timeout_nxt;
            r_in_cnt    <= w_in_cnt_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    assign o_s_ready   = r_s_ready;
    assign o_core_rst  = r_core_rst;
    assign o_core_key  = r_core_key;
    assign o_core_din  = r_core_din;
    assign o_m_valid   = r_m_valid;
    assign o_m_data    = r_m_data;
    assign o_m_timeout = r_m_timeout;

endmodule

// File: tb/tb_aes_serdes_driver.sv
// Bench for aes_serdes_driver: a behavioural core (ciphertext = key ^ plaintext) driven
// cycle by cycle, with expected blocks and arrival times derived from the block-level rules.
module tb_aes_serdes_driver;

    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready;
    logic [127:0] s_key, s_data;
    logic         core_rst, core_dvld;
    logic [7:0]   core_key, core_din, core_dout;
    logic         m_valid, m_ready, m_timeout;
    logic [127:0] m_data;

    logic         s_valid32, s_ready32;
    logic [127:0] s_key32, s_data32;
    logic         core_rst32, core_dvld32;
    logic [31:0]  core_key32, core_din32, core_dout32;
    logic         m_valid32, m_ready32, m_timeout32;
    logic [127:0] m_data32;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_serdes_driver #(.BLK_W(128), .BUS_W(8), .TIMEOUT(TMO)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_key(s_key), .i_s_data(s_data),
        .o_core_rst(core_rst), .o_core_key(core_key), .o_core_din(core_din),
        .i_core_dout(core_dout), .i_core_dvld(core_dvld),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_timeout(m_timeout)
    );

    aes_serdes_driver #(.BLK_W(128), .BUS_W(32), .TIMEOUT(1023)) u_dut32 (
        .i_clk(clk), .i_rst(rst),
        .i_s_valid(s_valid32), .o_s_ready(s_ready32), .i_s_key(s_key32), .i_s_data(s_data32),
        .o_core_rst(core_rst32), .o_core_key(core_key32), .o_core_din(core_din32),
        .i_core_dout(core_dout32), .i_core_dvld(core_dvld32),
        .o_m_valid(m_valid32), .i_m_ready(m_ready32), .o_m_data(m_data32),
        .o_m_timeout(m_timeout32)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] beat8(input logic [127:0] v, input int k);
        return v[127-8*k -: 8];
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_core_key"}, core_key, 0);
        chk({tag, "_core_din"}, core_din, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_timeout"}, m_timeout, 0);
    endtask

    // lat: idle WAIT cycles before the core answers; n_emit: beats the core produces;
    // bp: cycles m_ready is held low in DONE; rst_beat: load beat at which rst is raised.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input int lat,
                             input int n_emit, input int bp, input int rst_beat,
                             input bit noise);
        logic [127:0] ct, exp_data;
        int got, idx_arrive, w, e;
        bit exp_tmo, seen;
        ct       = key ^ pt;
        got      = (TMO - lat) < n_emit ? (TMO - lat) : n_emit;
        exp_tmo  = (got < 16);
        exp_data = exp_tmo ? (ct >> (8 * (16 - got))) : ct;
        idx_arrive = exp_tmo ? TMO : lat + 16;
        m_ready  = (bp == 0);
        w = 0;
        while (!s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("s_ready_idle", s_ready, 1);
        if (!s_ready) return;
        s_key = key; s_data = pt; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("s_ready_drop", s_ready, 0);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("core_key_b%0d", k), core_key, beat8(key, k));
            chk($sformatf("core_din_b%0d", k), core_din, beat8(pt, k));
            chk($sformatf("core_rst_b%0d", k), core_rst, 0);
            if (noise) begin
                s_valid = 1'b1;
                s_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (k == rst_beat) begin
                rst = 1'b1; s_valid = 1'b0;
                @(negedge clk);
                chk_reset("midrst");
                rst = 1'b0;
                return;
            end
        end
        s_valid = 1'b0; s_key = key;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("wait_core_key", core_key, 0);
                chk("wait_core_rst", core_rst, 0);
            end
            if (m_valid) begin
                seen = 1'b1;
                core_dvld = 1'b0;
                chk("arrive_cycle", i, idx_arrive);
            end else begin
                e = i - lat;
                core_dvld = (e >= 0 && e < n_emit);
                core_dout = core_dvld ? beat8(ct, e) : 8'h00;
            end
        end
        chk("m_valid_seen", seen, 1);
        chk("m_data", m_data, exp_data);
        chk("m_timeout", m_timeout, exp_tmo);
        for (int b = 0; b < bp; b++) begin
            core_dvld = 1'b1;
            core_dout = 8'($urandom());
            @(negedge clk);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, exp_data);
            chk("bp_m_timeout", m_timeout, exp_tmo);
            chk("bp_s_ready", s_ready, 0);
        end
        core_dvld = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("m_valid_drop", m_valid, 0);
        chk("s_ready_back", s_ready, 1);
    endtask

    initial begin
        logic [127:0] k32, p32;
        rst = 1'b1;
        s_valid = 1'b0; s_key = '0; s_data = '0;
        core_dvld = 1'b0; core_dout = '0; m_ready = 1'b1;
        s_valid32 = 1'b0; s_key32 = '0; s_data32 = '0;
        core_dvld32 = 1'b0; core_dout32 = '0; m_ready32 = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);

        run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  2, 16, 0, -1, 1'b0);
        run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  0, 16, 0, -1, 1'b0);
        // Last beat lands on the watchdog's final cycle.
        run_block(128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h1, 4, 16, 0, -1, 1'b0);
        // One cycle later and only 15 beats make it in.
        run_block(128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'hffff, 5, 16, 0, -1, 1'b0);
        run_block(128'h13579bdf_2468ace0_fedcba98_76543210, 128'h5a5a, 1, 16, 5, -1, 1'b0);
        run_block(128'h11111111_22222222_33333333_44444444, 128'h77, 1, 3, 2, -1, 1'b0);
        run_block(128'haaaa5555_aaaa5555_aaaa5555_aaaa5555, 128'h9, 0, 16, 0, 7, 1'b0);
        run_block(128'h00000000_11111111_22222222_33333333, 128'h3c, 3, 16, 1, -1, 1'b0);
        run_block(128'hcafebabe_cafebabe_cafebabe_cafebabe, 128'h42, 0, 16, 0, -1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            run_block({$urandom(), $urandom(), $urandom(), $urandom()},
                      {$urandom(), $urandom(), $urandom(), $urandom()},
                      int'($urandom_range(0, 4)), 16, int'($urandom_range(0, 3)), -1, 1'b0);
        end

        // 32-bit beats with an echoing core: four load cycles, result equals plaintext.
        k32 = {$urandom(), $urandom(), $urandom(), $urandom()};
        p32 = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("w32_s_ready", s_ready32, 1);
        s_key32 = k32; s_data32 = p32; s_valid32 = 1'b1;
        @(negedge clk);
        s_valid32 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("w32_key_b%0d", k), core_key32, k32[127-32*k -: 32]);
            chk($sformatf("w32_din_b%0d", k), core_din32, p32[127-32*k -: 32]);
            chk($sformatf("w32_rst_b%0d", k), core_rst32, 0);
        end
        @(negedge clk);
        chk("w32_wait_din", core_din32, 0);
        chk("w32_wait_rst", core_rst32, 0);
        for (int k = 0; k < 4; k++) begin
            core_dvld32 = 1'b1;
            core_dout32 = p32[127-32*k -: 32];
            @(negedge clk);
        end
        core_dvld32 = 1'b0;
        chk("w32_m_valid", m_valid32, 1);
        chk("w32_m_data", m_data32, p32);
        chk("w32_m_timeout", m_timeout32, 0);
        @(negedge clk);
        chk("w32_m_valid_drop", m_valid32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
